// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states, STATUS layout.
package irq_ctrl_pkg;

  localparam int unsigned VW = 3;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  localparam int unsigned STATUS_INSVC_BIT = 15;
  localparam int unsigned STATUS_LOST_LSB  = 8;
  localparam int unsigned STATUS_LOST_W    = 7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the mask wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0] mask,
  output logic             valid,
  output logic [VW-1:0]    idx
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (mask[k]) begin
        valid = 1'b1;
        idx   = VW'(k);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with MMIO registers and a single-level service FSM.
// Optional lost-edge tracking in STATUS[14:8] is built when IRQ_CTRL_LOST_EN is defined.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [1:0]       i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  output logic             o_rdy,
  input  logic [N_SRC-1:0] i_irq,
  output logic             o_irq,
  output logic [VW-1:0]    o_vec,
  input  logic             i_ack
);

  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [VW-1:0]    vec_q, vec_d;
  irq_state_e       state_q, state_d;

  logic             win_valid;
  logic [VW-1:0]    win_idx;
  logic             ack_take;
  logic             wr_en, rd_en, eoi_wr;
  logic [N_SRC-1:0] rise, w1c_mask, ack_mask;
  logic             unused_wdata;

  assign wr_en  = i_sel & i_we;
  assign rd_en  = i_sel & i_re;
  assign eoi_wr = wr_en && (i_addr == ADDR_EOI);
  assign rise   = i_irq & ~irq_q;
  assign o_rdy  = i_sel;

  assign unused_wdata = ^i_wdata[15:N_SRC];

  irq_prio_enc #(
    .N_SRC(N_SRC)
  ) u_prio (
    .mask (pending_q & enable_q),
    .valid(win_valid),
    .idx  (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ack_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) state_d = StReq;
      end
      StReq: begin
        if (!win_valid) begin
          state_d = StIdle;
        end else if (i_ack) begin
          ack_take = 1'b1;
          vec_d    = win_idx;
          state_d  = StService;
        end
      end
      StService: begin
        if (eoi_wr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ack_mask = ack_take ? (N_SRC'(1) << win_idx) : '0;
  assign w1c_mask = (wr_en && (i_addr == ADDR_PENDING)) ? i_wdata[N_SRC-1:0] : '0;

  // New edges win over any clear landing on the same bit.
  assign pending_d = (pending_q & ~(w1c_mask | ack_mask)) | rise;
  assign enable_d  = (wr_en && (i_addr == ADDR_ENABLE)) ? i_wdata[N_SRC-1:0] : enable_q;

  // Edge register tracks the inputs even in reset so a level held across release is not an edge.
  always_ff @(posedge i_clk) begin
    irq_q <= i_irq;
    if (!i_rst_n) begin
      enable_q  <= '0;
      pending_q <= '0;
      vec_q     <= '0;
      state_q   <= StIdle;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      state_q   <= state_d;
    end
  end

  assign o_irq = (state_q == StReq) & win_valid;
  assign o_vec = (state_q == StReq) ? win_idx : vec_q;

`ifdef IRQ_CTRL_LOST_EN
  logic [N_SRC-1:0]         lost_q;
  logic [STATUS_LOST_W-1:0] lost_vis;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lost_q <= '0;
    end else begin
      lost_q <= (lost_q & ~{N_SRC{rd_en && (i_addr == ADDR_STATUS)}}) | (rise & pending_q);
    end
  end

  assign lost_vis = STATUS_LOST_W'(lost_q);
`endif

  always_comb begin
    o_rdata = 16'h0000;
    if (rd_en) begin
      unique case (i_addr)
        ADDR_ENABLE:  o_rdata[N_SRC-1:0] = enable_q;
        ADDR_PENDING: o_rdata[N_SRC-1:0] = pending_q;
        ADDR_STATUS: begin
          o_rdata[STATUS_INSVC_BIT] = (state_q == StService);
          o_rdata[VW-1:0]           = o_vec;
`ifdef IRQ_CTRL_LOST_EN
          o_rdata[STATUS_LOST_LSB +: STATUS_LOST_W] = lost_vis;
`endif
        end
        ADDR_EOI:     o_rdata = 16'h0000;
        default:      o_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard-driven bench for irq_ctrl; lost-edge checks follow IRQ_CTRL_LOST_EN.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int unsigned N_SRC = 4;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_sel, i_we, i_re, i_ack;
  logic [1:0]       i_addr;
  logic [15:0]      i_wdata;
  logic [15:0]      o_rdata;
  logic             o_rdy, o_irq;
  logic [N_SRC-1:0] i_irq;
  logic [2:0]       o_vec;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 i_clk = ~i_clk;

  irq_ctrl #(
    .N_SRC(N_SRC)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_sel  (i_sel),
    .i_we   (i_we),
    .i_re   (i_re),
    .i_addr (i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_rdy  (o_rdy),
    .i_irq  (i_irq),
    .o_irq  (o_irq),
    .o_vec  (o_vec),
    .i_ack  (i_ack)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    i_sel   = 1'b1;
    i_we    = 1'b1;
    i_addr  = addr;
    i_wdata = data;
    cyc();
    i_sel   = 1'b0;
    i_we    = 1'b0;
    i_wdata = 16'h0000;
  endtask

  // Read held across one edge so read side effects (LOST clear) take place.
  task automatic rd_chk(input logic [1:0] addr, input logic [15:0] exp, input string tag);
    i_sel  = 1'b1;
    i_re   = 1'b1;
    i_addr = addr;
    sb_push(tag, exp);
    #1;
    check_val({tag, "_rdy"}, {15'b0, o_rdy}, 16'd1);
    sb_pop(o_rdata);
    cyc();
    i_sel = 1'b0;
    i_re  = 1'b0;
  endtask

  task automatic out_chk(input logic irq, input logic [2:0] vec, input logic use_vec,
                         input string tag);
    sb_push(tag, {12'b0, irq, use_vec ? vec : 3'b000});
    #1;
    sb_pop({12'b0, o_irq, use_vec ? o_vec : 3'b000});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cnt;
    logic        tmr;
    int          lat;

    i_rst_n = 1'b0;
    i_sel   = 1'b0;
    i_we    = 1'b0;
    i_re    = 1'b0;
    i_ack   = 1'b0;
    i_addr  = 2'd0;
    i_wdata = 16'h0000;
    i_irq   = 4'b0100;
    repeat (3) cyc();
    i_rst_n = 1'b1;
    cyc();

    // Reset state; irq[2] high through release must not pend.
    rd_chk(ADDR_ENABLE, 16'h0000, "rst_enable");
    rd_chk(ADDR_PENDING, 16'h0000, "rst_pending");
    rd_chk(ADDR_STATUS, 16'h0000, "rst_status");
    rd_chk(ADDR_EOI, 16'h0000, "rst_eoi");
    out_chk(1'b0, 3'd0, 1'b1, "rst_out");
    check_val("rdata_idle", o_rdata, 16'h0000);
    i_irq = '0;
    cyc();

    // Single source, ack moves to service.
    wr(ADDR_ENABLE, 16'h0003);
    i_irq[1] = 1'b1;
    cyc();
    out_chk(1'b0, 3'd0, 1'b0, "a_idle");
    rd_chk(ADDR_PENDING, 16'h0002, "a_pend");
    out_chk(1'b1, 3'd1, 1'b1, "a_req");
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    rd_chk(ADDR_PENDING, 16'h0000, "a_pend_ack");
    rd_chk(ADDR_STATUS, 16'h8001, "a_status");
    out_chk(1'b0, 3'd1, 1'b1, "a_svc");
    wr(ADDR_EOI, 16'h0000);
    i_irq = '0;
    cyc();

    // Simultaneous edges: lowest index first, then the other after EOI.
    i_irq[1:0] = 2'b11;
    cyc();
    cyc();
    out_chk(1'b1, 3'd0, 1'b1, "b_req0");
    wr(ADDR_EOI, 16'h0000);
    out_chk(1'b1, 3'd0, 1'b1, "b_eoi_in_req");
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    rd_chk(ADDR_STATUS, 16'h8000, "b_svc0");
    wr(ADDR_EOI, 16'h0000);
    cyc();
    out_chk(1'b1, 3'd1, 1'b1, "b_req1");
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    wr(ADDR_EOI, 16'h0000);
    i_irq = '0;
    rd_chk(ADDR_PENDING, 16'h0000, "b_pend_done");

    // Pending while masked; enable raises, disable withdraws before ack.
    wr(ADDR_ENABLE, 16'h0000);
    i_irq[2] = 1'b1;
    cyc();
    cyc();
    out_chk(1'b0, 3'd0, 1'b0, "c_masked");
    rd_chk(ADDR_PENDING, 16'h0004, "c_pend");
    wr(ADDR_ENABLE, 16'h0004);
    out_chk(1'b0, 3'd0, 1'b0, "c_en_idle");
    cyc();
    out_chk(1'b1, 3'd2, 1'b1, "c_req");
    wr(ADDR_ENABLE, 16'h0000);
    out_chk(1'b0, 3'd0, 1'b0, "c_disabled");
    cyc();
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    rd_chk(ADDR_PENDING, 16'h0004, "c_ack_ignored");
    wr(ADDR_PENDING, 16'h0004);
    rd_chk(ADDR_PENDING, 16'h0000, "c_w1c");
    i_irq = '0;
    cyc();

    // Edge and W1C on the same bit in the same cycle.
    i_irq[0] = 1'b1;
    wr(ADDR_PENDING, 16'h0001);
    rd_chk(ADDR_PENDING, 16'h0001, "d_set_wins");
    wr(ADDR_PENDING, 16'h0001);
    rd_chk(ADDR_PENDING, 16'h0000, "d_cleared");
    i_irq = '0;
    cyc();

    // timer16 model from 0xFFFC driving irq[0]; then reset during service.
    wr(ADDR_ENABLE, 16'h0001);
    cnt = 16'hFFFC;
    tmr = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      cyc();
      if (cnt == 16'hFFFF) tmr = 1'b1;
      cnt      = cnt + 16'd1;
      i_irq[0] = tmr;
      #1;
      if (o_irq) lat = i;
    end
    check_val("e_latency_le6", 16'(lat >= 1 && lat <= 6), 16'd1);
    out_chk(1'b1, 3'd0, 1'b1, "e_req");
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    rd_chk(ADDR_STATUS, 16'h8000, "e_svc");
    i_rst_n = 1'b0;
    cyc();
    rd_chk(ADDR_STATUS, 16'h0000, "e_rst_status");
    out_chk(1'b0, 3'd0, 1'b1, "e_rst_out");
    i_rst_n = 1'b1;
    cyc();
    rd_chk(ADDR_PENDING, 16'h0000, "e_pend_after_rst");
    rd_chk(ADDR_ENABLE, 16'h0000, "e_en_after_rst");
    i_irq = '0;
    cyc();

    // Two edges on irq[3] without service.
    i_irq[3] = 1'b1;
    cyc();
    i_irq[3] = 1'b0;
    cyc();
    i_irq[3] = 1'b1;
    cyc();
    i_irq[3] = 1'b0;
    cyc();
`ifdef IRQ_CTRL_LOST_EN
    rd_chk(ADDR_STATUS, 16'h0800, "f_lost");
    rd_chk(ADDR_STATUS, 16'h0000, "f_lost_clr");
`else
    rd_chk(ADDR_STATUS, 16'h0000, "f_no_lost");
`endif
    rd_chk(ADDR_PENDING, 16'h0008, "f_pend");

    check_val("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of interrupt sources (2..8); vector width VW = 3.
REQ-002 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have ports i_sel, i_we, i_re  input  1 each  MMIO select, write strobe, read strobe.
REQ-005 SHALL have port i_addr  input  2  register address.
REQ-006 SHALL have port i_wdata  input  16  write data.
REQ-007 SHALL have port o_rdata  output  16  read data.
REQ-008 SHALL have port o_rdy  output  1  access complete.
REQ-009 SHALL have port i_irq  input  N_SRC  level requests from peripheral o_int_req lines (timer16 = bit 0, timerH = bit 1).
REQ-010 SHALL have port o_irq  output  1  interrupt request to CPU.
REQ-011 SHALL have port o_vec  output  3  index of the requested or in-service source.
REQ-012 SHALL have port i_ack  input  1  CPU acknowledge, single-cycle pulse.

Function
REQ-013 SHALL use the register map: 0 = ENABLE (RW, bits N_SRC-1:0); 1 = PENDING (read; write-1-to-clear); 2 = STATUS (read: bit 15 = in_service, bits 2:0 = o_vec); 3 = EOI (write any value ends service; reads 0).
REQ-014 SHALL drive o_rdy = i_sel combinationally, giving zero-wait single-cycle accesses.
REQ-015 SHALL produce o_rdata combinationally from i_addr when i_sel & i_re, otherwise 16'h0000; unused bits read 0.
REQ-016 SHALL register i_irq every cycle and set PENDING[k] on a 0->1 transition of i_irq[k], regardless of ENABLE.
REQ-017 SHALL select, each cycle, the lowest index k with PENDING[k] & ENABLE[k] as the winner.
REQ-018 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-019 SHALL move IDLE->REQ on the cycle after a winner exists, with o_irq = 1 and o_vec = winner while in REQ.
REQ-020 SHALL re-evaluate the winner every cycle in REQ, and SHALL return REQ->IDLE with o_irq = 0 if no winner remains (disabled or cleared before ack).
REQ-021 SHALL, on i_ack in REQ, latch o_vec, clear that PENDING bit, and enter SERVICE next cycle; in SERVICE o_irq = 0 and o_vec is held.
REQ-022 SHALL ignore i_ack outside REQ.
REQ-023 SHALL move SERVICE->IDLE on a write to EOI; an EOI write in IDLE/REQ is ignored. Nesting is not supported.
REQ-024 SHALL give a set priority over a clear for a simultaneous set and clear (edge vs W1C, or edge vs ack) on the same PENDING bit: the bit ends at 1.

Reset
REQ-025 SHALL, while i_rst_n = 0 at a clock edge, clear ENABLE, PENDING, and the latched vector, and set the state to IDLE, o_irq = 0, and o_vec = 0.
REQ-026 SHALL load the edge-detect register with i_irq during reset, so that a request already high at reset release creates no pending bit.
REQ-027 SHALL abandon any REQ/SERVICE in progress when reset is asserted mid-operation, with no residual state.

Configuration
REQ-028 SHALL, with IRQ_CTRL_LOST_EN defined, keep LOST bits (STATUS bits 8+k) set by an edge on a source whose PENDING is already 1, cleared on a read of STATUS (i_sel & i_re & addr 2).
REQ-029 SHALL, without IRQ_CTRL_LOST_EN, read STATUS bits 14:8 as 0 and include no LOST logic.

Structure
REQ-030 SHALL place the register address constants (ADDR_ENABLE/PENDING/STATUS/EOI), FSM state encodings, and STATUS bit positions in shared package irq_ctrl_pkg.
REQ-031 SHALL implement the winner selection in one sub-module, irq_prio_enc: combinational, taking an N_SRC mask and giving a valid flag and a 3-bit index.

Verification
REQ-032 SHALL cover: ENABLE = 0x0003, rising edge on i_irq[1] -> PENDING = 0x0002; next cycle o_irq = 1, o_vec = 1; i_ack -> PENDING = 0, STATUS = 0x8001, o_irq = 0.
REQ-033 SHALL cover: edges on i_irq[0] and i_irq[1] in the same cycle with ENABLE = 0x0003 -> o_vec = 0 first; ack + EOI -> REQ again with o_vec = 1.
REQ-034 SHALL cover: PENDING bit 2 set with ENABLE = 0 -> o_irq stays 0; write ENABLE = 0x0004 -> o_irq = 1 next cycle; write ENABLE = 0 before ack -> o_irq = 0 next cycle.
REQ-035 SHALL cover: W1C write 0x0001 to PENDING in the same cycle as an i_irq[0] edge -> PENDING[0] remains 1.
REQ-036 SHALL cover: timer16 programmed with start 0xFFFC driving i_irq[0] -> o_irq within 6 cycles of counter start; i_i_rst_n low in SERVICE -> next cycle state IDLE, STATUS = 0x0000.
REQ-037 SHALL cover, with IRQ_CTRL_LOST_EN defined: two i_irq[3] edges with no ack -> STATUS bit 11 = 1; a second STATUS read returns bit 11 = 0.
